// File: rtl/npu_load_pkg.sv
// Shared types and default geometry for the NPU host loader.
package npu_load_pkg;

  typedef enum logic [1:0] {
    S_IMAGE = 2'd0,
    S_CONV  = 2'd1,
    S_DENSE = 2'd2,
    S_DONE  = 2'd3
  } load_phase_t;

  localparam int NPU_BUS_W       = 32;
  localparam int NPU_BYTE_W      = 8;
  localparam int NPU_IMG_WORDS   = 196;
  localparam int NPU_CONV_BYTES  = 55744;
  localparam int NPU_DENSE_BYTES = 37578;
  localparam int NPU_IMG_AW      = 14;
  localparam int NPU_CONV_AW     = 16;
  localparam int NPU_DENSE_AW    = 16;

endpackage

// File: rtl/npu_byte_unpacker.sv
// Splits one bus word into bytes, most-significant byte first.
// Byte 0 is offered combinationally in the load cycle; the rest follow one per cycle.
module npu_byte_unpacker #(
  parameter int BUS_W  = 32,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              flush,
  input  logic [BUS_W-1:0]  data,
  output logic              byte_valid,
  output logic [BYTE_W-1:0] byte_out,
  output logic              busy
);

  localparam int LANES = BUS_W / BYTE_W;
  localparam int CW    = $clog2(LANES + 1);

  logic [BUS_W-1:0] shift_q;
  logic [CW-1:0]    left_q;

  assign busy       = (left_q != '0);
  assign byte_valid = load | busy;
  assign byte_out   = load ? data[BUS_W-1 -: BYTE_W] : shift_q[BUS_W-1 -: BYTE_W];

  // NOTE: only the occupancy count is reset; the shift register is pure datapath
  // and is never read while the count is zero.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      left_q <= '0;
    end else if (load) begin
      shift_q <= data << BYTE_W;
      left_q  <= CW'(LANES - 1);
    end else if (busy) begin
      shift_q <= shift_q << BYTE_W;
      left_q  <= left_q - CW'(1);
    end
  end

endmodule

// File: rtl/npu_load_sequencer.sv
// Host-to-NPU loader: image words in parallel, then conv and dense weights byte-serial.
// Optional running byte checksum under `NPU_LOAD_CHECKSUM_EN; img_data lane k sits where byte k sits in the word.
module npu_load_sequencer
  import npu_load_pkg::*;
#(
  parameter int BUS_W       = NPU_BUS_W,
  parameter int BYTE_W      = NPU_BYTE_W,
  parameter int IMG_WORDS   = NPU_IMG_WORDS,
  parameter int CONV_BYTES  = NPU_CONV_BYTES,
  parameter int DENSE_BYTES = NPU_DENSE_BYTES,
  parameter int IMG_AW      = NPU_IMG_AW,
  parameter int CONV_AW     = NPU_CONV_AW,
  parameter int DENSE_AW    = NPU_DENSE_AW,
  localparam int LANES      = BUS_W / BYTE_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BUS_W-1:0]        writedata,
  input  logic                    write,
  input  logic                    chipselect,
  input  logic                    restart,
  output logic                    waitrequest,
  output logic [IMG_AW-1:0]       img_addr,
  output logic [LANES*BYTE_W-1:0] img_data,
  output logic [LANES-1:0]        img_wren,
  output logic [CONV_AW-1:0]      conv_addr,
  output logic [BYTE_W-1:0]       conv_data,
  output logic                    conv_wren,
  output logic [DENSE_AW-1:0]     dense_addr,
  output logic [BYTE_W-1:0]       dense_data,
  output logic                    dense_wren,
  output logic [1:0]              phase,
  output logic                    done,
  output logic [15:0]             checksum
);

  localparam int IMG_CW   = $clog2(IMG_WORDS + 1);
  localparam int CONV_CW  = $clog2(CONV_BYTES + 1);
  localparam int DENSE_CW = $clog2(DENSE_BYTES + 1);

  load_phase_t         phase_q;
  logic [IMG_CW-1:0]   img_cnt;
  logic [CONV_CW-1:0]  conv_cnt;
  logic [DENSE_CW-1:0] dense_cnt;

  logic              accept, unp_load, unp_flush, byte_valid, busy;
  logic              img_last, conv_last, dense_last;
  logic [BYTE_W-1:0] byte_out;

  assign waitrequest = busy;
  assign accept      = write & chipselect & ~busy;
  assign unp_load    = accept & ((phase_q == S_CONV) | (phase_q == S_DENSE));

  assign img_last   = (img_cnt == IMG_CW'(IMG_WORDS - 1));
  assign conv_last  = (phase_q == S_CONV) && (conv_cnt == CONV_CW'(CONV_BYTES - 1));
  assign dense_last = (phase_q == S_DENSE) && (dense_cnt == DENSE_CW'(DENSE_BYTES - 1));
  // Segment end drops whatever bytes of the current word are still queued.
  assign unp_flush  = byte_valid & (conv_last | dense_last);

  npu_byte_unpacker #(
    .BUS_W  (BUS_W),
    .BYTE_W (BYTE_W)
  ) u_unpacker (
    .clk        (clk),
    .reset      (reset),
    .load       (unp_load),
    .flush      (unp_flush),
    .data       (writedata),
    .byte_valid (byte_valid),
    .byte_out   (byte_out),
    .busy       (busy)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= S_IMAGE;
      img_cnt    <= '0;
      conv_cnt   <= '0;
      dense_cnt  <= '0;
      img_addr   <= '0;
      img_data   <= '0;
      img_wren   <= '0;
      conv_addr  <= '0;
      conv_data  <= '0;
      conv_wren  <= 1'b0;
      dense_addr <= '0;
      dense_data <= '0;
      dense_wren <= 1'b0;
    end else begin
      img_wren   <= '0;
      conv_wren  <= 1'b0;
      dense_wren <= 1'b0;
      case (phase_q)
        S_IMAGE: if (accept) begin
          img_wren <= '1;
          img_data <= writedata;
          img_addr <= IMG_AW'(img_cnt);
          img_cnt  <= img_cnt + IMG_CW'(1);
          if (img_last) phase_q <= S_CONV;
        end
        S_CONV: if (byte_valid) begin
          conv_wren <= 1'b1;
          conv_data <= byte_out;
          conv_addr <= CONV_AW'(conv_cnt);
          conv_cnt  <= conv_cnt + CONV_CW'(1);
          if (conv_last) phase_q <= S_DENSE;
        end
        S_DENSE: if (byte_valid) begin
          dense_wren <= 1'b1;
          dense_data <= byte_out;
          dense_addr <= DENSE_AW'(dense_cnt);
          dense_cnt  <= dense_cnt + DENSE_CW'(1);
          if (dense_last) phase_q <= S_DONE;
        end
        default: if (restart) begin
          img_cnt    <= '0;
          conv_cnt   <= '0;
          dense_cnt  <= '0;
          img_addr   <= '0;
          conv_addr  <= '0;
          dense_addr <= '0;
          phase_q    <= S_IMAGE;
        end
      endcase
    end
  end

  assign phase = phase_q;
  assign done  = (phase_q == S_DONE);

`ifdef NPU_LOAD_CHECKSUM_EN
  logic [15:0] sum_q, img_sum, sum_add;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    img_sum = '0;
    for (int k = 0; k < LANES; k++) img_sum += 16'(img_data[k*BYTE_W +: BYTE_W]);
    sum_add = (img_wren[0] ? img_sum : 16'd0)
            + (conv_wren ? 16'(conv_data) : 16'd0)
            + (dense_wren ? 16'(dense_data) : 16'd0);
  end

  // Sums the registered RAM writes, so it trails each wren by one cycle.
  always_ff @(posedge clk) begin
    if (reset || (phase_q == S_DONE && restart)) sum_q <= '0;
    else                                         sum_q <= sum_q + sum_add;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_npu_load_sequencer.sv
// Randomised bench for npu_load_sequencer against a queue-based transaction model.
module tb_npu_load_sequencer;

  localparam int BUS_W       = 32;
  localparam int BYTE_W      = 8;
  localparam int LANES       = 4;
  localparam int IMG_WORDS   = 196;
  localparam int CONV_BYTES  = 2000;
  localparam int DENSE_BYTES = 1502;
  localparam int IMG_AW      = 14;
  localparam int CONV_AW     = 16;
  localparam int DENSE_AW    = 16;

  logic                clk = 1'b0;
  logic                reset, write, chipselect, restart;
  logic [BUS_W-1:0]    writedata;
  logic                waitrequest;
  logic [IMG_AW-1:0]   img_addr;
  logic [BUS_W-1:0]    img_data;
  logic [LANES-1:0]    img_wren;
  logic [CONV_AW-1:0]  conv_addr;
  logic [7:0]          conv_data;
  logic                conv_wren;
  logic [DENSE_AW-1:0] dense_addr;
  logic [7:0]          dense_data;
  logic                dense_wren;
  logic [1:0]          phase;
  logic                done;
  logic [15:0]         checksum;

  always #5 clk = ~clk;

  npu_load_sequencer #(
    .BUS_W(BUS_W), .BYTE_W(BYTE_W), .IMG_WORDS(IMG_WORDS), .CONV_BYTES(CONV_BYTES),
    .DENSE_BYTES(DENSE_BYTES), .IMG_AW(IMG_AW), .CONV_AW(CONV_AW), .DENSE_AW(DENSE_AW)
  ) dut (
    .clk(clk), .reset(reset), .writedata(writedata), .write(write),
    .chipselect(chipselect), .restart(restart), .waitrequest(waitrequest),
    .img_addr(img_addr), .img_data(img_data), .img_wren(img_wren),
    .conv_addr(conv_addr), .conv_data(conv_data), .conv_wren(conv_wren),
    .dense_addr(dense_addr), .dense_data(dense_data), .dense_wren(dense_wren),
    .phase(phase), .done(done), .checksum(checksum)
  );

  int checks = 0;
  int errors = 0;

  // Model: every RAM write the host has earned, in order; one leaves per cycle.
  typedef struct {
    int          dest;
    int          addr;
    logic [31:0] data;
    bit          last;
  } ev_t;

  ev_t         pend[$];
  int          m_phase, n_img, n_conv, n_dense;
  bit          e_img, e_conv, e_dense;
  int          e_addr;
  logic [31:0] e_data;
  int          e_csum, cur_sum;

  int          dense_pulses, last_dense_addr, conv_seen;
  logic [7:0]  conv_first [4];
  logic [7:0]  img195_lane0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int byte_sum(input logic [31:0] w);
    return int'(w[31:24]) + int'(w[23:16]) + int'(w[15:8]) + int'(w[7:0]);
  endfunction

  task automatic model_edge(input bit r, input bit w, input bit c, input bit rs,
                            input logic [31:0] d);
    bit  acc;
    int  len, n, k;
    ev_t e;
    if (r) begin
      pend.delete();
      m_phase = 0; n_img = 0; n_conv = 0; n_dense = 0;
      e_img = 0; e_conv = 0; e_dense = 0;
      e_csum = 0; cur_sum = 0;
      return;
    end
    e_csum  = (e_csum + cur_sum) % 65536;
    cur_sum = 0;
    e_img = 0; e_conv = 0; e_dense = 0;
    acc = w && c && (pend.size() == 0);
    if (m_phase == 3) begin
      if (rs) begin
        n_img = 0; n_conv = 0; n_dense = 0; m_phase = 0; e_csum = 0;
      end
    end else if (acc) begin
      if (m_phase == 0) begin
        pend.push_back('{0, n_img, d, (n_img == IMG_WORDS - 1)});
        n_img++;
      end else begin
        len = (m_phase == 1) ? CONV_BYTES : DENSE_BYTES;
        n   = (m_phase == 1) ? n_conv : n_dense;
        k   = (len - n < LANES) ? len - n : LANES;
        for (int j = 0; j < k; j++)
          pend.push_back('{m_phase, n + j, {24'b0, d[31-8*j -: 8]}, ((n + j) == len - 1)});
        if (m_phase == 1) n_conv += k;
        else              n_dense += k;
      end
    end
    if (pend.size() != 0) begin
      e      = pend.pop_front();
      e_addr = e.addr;
      e_data = e.data;
      case (e.dest)
        0:       begin e_img = 1;   cur_sum = byte_sum(e.data); end
        1:       begin e_conv = 1;  cur_sum = int'(e.data); end
        default: begin e_dense = 1; cur_sum = int'(e.data); end
      endcase
      if (e.last) m_phase++;
    end
  endtask

  task automatic compare();
    check("waitrequest", {31'b0, waitrequest}, {31'b0, pend.size() != 0});
    check("phase", {30'b0, phase}, m_phase);
    check("done", {31'b0, done}, {31'b0, m_phase == 3});
    check("wren", {26'b0, img_wren, conv_wren, dense_wren},
          {26'b0, {4{e_img}}, e_conv, e_dense});
    if (e_img) begin
      check("img_addr", {18'b0, img_addr}, e_addr);
      check("img_data", img_data, e_data);
    end
    if (e_conv) begin
      check("conv_addr", {16'b0, conv_addr}, e_addr);
      check("conv_data", {24'b0, conv_data}, e_data);
    end
    if (e_dense) begin
      check("dense_addr", {16'b0, dense_addr}, e_addr);
      check("dense_data", {24'b0, dense_data}, e_data);
    end
`ifdef NPU_LOAD_CHECKSUM_EN
    check("checksum", {16'b0, checksum}, e_csum);
`else
    check("checksum", {16'b0, checksum}, 0);
`endif
    if (dense_wren) begin
      dense_pulses++;
      last_dense_addr = int'(dense_addr);
    end
    if (conv_wren && conv_seen < 4) begin
      conv_first[conv_seen] = conv_data;
      conv_seen++;
    end
    if (img_wren[0] && img_addr == 14'd195) img195_lane0 = img_data[31:24];
  endtask

  task automatic cycle(input bit r, input bit w, input bit c, input bit rs,
                       input logic [31:0] d);
    reset = r; write = w; chipselect = c; restart = rs; writedata = d;
    model_edge(r, w, c, rs, d);
    @(negedge clk);
    compare();
  endtask

  function automatic logic [31:0] dir_word();
    if (m_phase == 0)      return 32'hA0B1C2D3 + 32'(n_img);
    else if (m_phase == 1) return 32'h11223344 + 32'(n_conv) * 32'h00010203;
    else                   return 32'hC0DE0000 ^ 32'(n_dense);
  endfunction

  // mode 0: random host with gaps, held data and stray restarts; 1: all 0x01; 2: directed words
  task automatic run_load(input int mode, input int max_cycles);
    logic [31:0] hd;
    bit          have, w, c, rs;
    int          cyc;
    have = 0; cyc = 0; hd = '0;
    dense_pulses = 0; last_dense_addr = -1;
    while (m_phase != 3 && cyc < max_cycles) begin
      case (mode)
        0: begin
          if (!have) begin hd = $urandom; have = 1; end
          w  = $urandom_range(0, 99) < 75;
          c  = $urandom_range(0, 99) < 90;
          rs = $urandom_range(0, 99) < 3;
        end
        1: begin hd = 32'h01010101; w = 1; c = 1; rs = 0; end
        default: begin hd = dir_word(); w = 1; c = 1; rs = 0; end
      endcase
      if (w && c && pend.size() == 0) have = 0;
      cycle(0, w, c, rs, hd);
      cyc++;
    end
    check("reach_done", {31'b0, done}, 1);
    check("dense_pulses", dense_pulses, DENSE_BYTES);
    check("dense_last_addr", last_dense_addr, DENSE_BYTES - 1);
  endtask

  initial begin
    int cyc;
    conv_seen = 0; img195_lane0 = '0;

    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("rst_img_addr", {18'b0, img_addr}, 0);
    check("rst_img_data", img_data, 0);
    check("rst_conv_addr", {16'b0, conv_addr}, 0);
    check("rst_conv_data", {24'b0, conv_data}, 0);
    check("rst_dense_addr", {16'b0, dense_addr}, 0);
    check("rst_dense_data", {24'b0, dense_data}, 0);
    cycle(0, 0, 0, 0, 0);

    run_load(2, 20000);
    check("img195_lane0", {24'b0, img195_lane0}, 32'hA0);
    check("conv_b0", {24'b0, conv_first[0]}, 32'h11);
    check("conv_b1", {24'b0, conv_first[1]}, 32'h22);
    check("conv_b2", {24'b0, conv_first[2]}, 32'h33);
    check("conv_b3", {24'b0, conv_first[3]}, 32'h44);

    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, $urandom);
    cycle(0, 1, 1, 1, 32'hDEADBEEF);
    check("restart_phase", {30'b0, phase}, 0);
    cycle(0, 0, 0, 0, 0);
    check("restart_no_img_wren", {28'b0, img_wren}, 0);

    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, $urandom);
    run_load(0, 20000);

    cycle(0, 0, 0, 1, 0);
    cyc = 0;
    while (!(m_phase == 1 && e_conv && pend.size() == 2) && cyc < 20000) begin
      cycle(0, 1, 1, 0, $urandom);
      cyc++;
    end
    check("mid_conv_wait", {31'b0, waitrequest}, 1);
    cycle(1, 0, 0, 0, 0);
    check("rst_conv_wren", {31'b0, conv_wren}, 0);
    check("rst_phase", {30'b0, phase}, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);

    run_load(1, 20000);
    cycle(0, 0, 0, 0, 0);
`ifdef NPU_LOAD_CHECKSUM_EN
    check("checksum_total", {16'b0, checksum}, (IMG_WORDS * LANES + CONV_BYTES + DENSE_BYTES) % 65536);
`else
    check("checksum_total", {16'b0, checksum}, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
